// File: rtl/mul_hilo_ctrl_pkg.sv
// Shared definitions for the HI/LO multiply controller: operand width,
// FSM state encodings and the read-select helper for MFHI/MFLO.
package mul_hilo_ctrl_pkg;

  localparam int MUL_WIDTH = 16;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LAUNCH = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;
  localparam logic [1:0] ST_WRITE  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE   = ST_IDLE,
    S_LAUNCH = ST_LAUNCH,
    S_WAIT   = ST_WAIT,
    S_WRITE  = ST_WRITE
  } state_e;

  // Read-port select codes; HI wins when both reads are asserted.
  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_LO   = 2'b01;
  localparam logic [1:0] SEL_HI   = 2'b10;

  function automatic logic [1:0] hilo_sel(input logic rd_hi, input logic rd_lo);
    if (rd_hi)      return SEL_HI;
    else if (rd_lo) return SEL_LO;
    else            return SEL_NONE;
  endfunction

endpackage

// File: rtl/mul_hilo_ctrl_neg_cond.sv
// Conditional two's-complement negation: out = neg ? -in : in (modulo 2^W).
// Used both for sign-magnitude conditioning of operands and for restoring
// the sign of the unsigned product.
module neg_cond #(
  parameter int W = 16
) (
  input  logic         neg_i,
  input  logic [W-1:0] in_i,
  output logic [W-1:0] out_o
);

  assign out_o = neg_i ? (~in_i + {{(W-1){1'b0}}, 1'b1}) : in_i;

endmodule

// File: rtl/mul_hilo_ctrl.sv
// HI/LO multiply controller: accepts MULT/MULTU, feeds operand magnitudes to
// an unsigned shift-add multiplier, sign-corrects the product into HI/LO and
// serves MFHI/MFLO/MTHI/MTLO, stalling the pipeline while a multiply runs.
module mul_hilo_ctrl
  import mul_hilo_ctrl_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) (
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic               Req,
  input  logic               Signed,
  input  logic [WIDTH-1:0]   OpA,
  input  logic [WIDTH-1:0]   OpB,
  output logic               Ack,
  output logic               Busy,
  output logic               Stall,
  input  logic               RdHi,
  input  logic               RdLo,
  output logic [WIDTH-1:0]   RdData,
  input  logic               WrHi,
  input  logic               WrLo,
  input  logic [WIDTH-1:0]   WrData,
  output logic               Mul_St,
  output logic [WIDTH-1:0]   Mul_Multiplicando,
  output logic [WIDTH-1:0]   Mul_Multiplicador,
  input  logic               Mul_Idle,
  input  logic               Mul_Done,
  input  logic [2*WIDTH-1:0] Mul_Produto
);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0]   mag_a_q, mag_a_d, mag_b_q, mag_b_d;
  logic               negres_q, negres_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;

  logic [WIDTH-1:0]   mag_a_w, mag_b_w;
  logic [2*WIDTH-1:0] res_w;
  logic               idle_w, busy_w, ack_w, stall_w;

  assign idle_w  = (state_q == S_IDLE);
  assign busy_w  = ~idle_w;
  assign ack_w   = idle_w & Req & Mul_Idle;
  // A request in IDLE must also hold while a multiplier left running by a
  // reset is still draining.
  assign stall_w = (busy_w & (Req | RdHi | RdLo | WrHi | WrLo))
                 | (idle_w & Req & ~Mul_Idle);

  neg_cond #(.W(WIDTH)) u_neg_a (
    .neg_i (Signed & OpA[WIDTH-1]),
    .in_i  (OpA),
    .out_o (mag_a_w)
  );

  neg_cond #(.W(WIDTH)) u_neg_b (
    .neg_i (Signed & OpB[WIDTH-1]),
    .in_i  (OpB),
    .out_o (mag_b_w)
  );

  neg_cond #(.W(2*WIDTH)) u_neg_p (
    .neg_i (negres_q),
    .in_i  (prod_q),
    .out_o (res_w)
  );

  // Next-state and datapath updates; product write in WRITE overrides any MT*.
  always_comb begin
    state_d  = state_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    mag_a_d  = mag_a_q;
    mag_b_d  = mag_b_q;
    negres_d = negres_q;
    prod_d   = prod_q;

    if (!stall_w) begin
      if (WrHi) hi_d = WrData;
      if (WrLo) lo_d = WrData;
    end

    case (state_q)
      S_IDLE: begin
        if (ack_w) begin
          mag_a_d  = mag_a_w;
          mag_b_d  = mag_b_w;
          negres_d = Signed & (OpA[WIDTH-1] ^ OpB[WIDTH-1]);
          state_d  = S_LAUNCH;
        end
      end
      S_LAUNCH: state_d = S_WAIT;
      S_WAIT: begin
        if (Mul_Done) begin
          prod_d  = Mul_Produto;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        hi_d    = res_w[2*WIDTH-1:WIDTH];
        lo_d    = res_w[WIDTH-1:0];
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and register update with asynchronous reset of everything.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q  <= S_IDLE;
      hi_q     <= '0;
      lo_q     <= '0;
      mag_a_q  <= '0;
      mag_b_q  <= '0;
      negres_q <= 1'b0;
      prod_q   <= '0;
    end else begin
      state_q  <= state_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      mag_a_q  <= mag_a_d;
      mag_b_q  <= mag_b_d;
      negres_q <= negres_d;
      prod_q   <= prod_d;
    end
  end

  // MFHI/MFLO read mux; HI has priority.
  always_comb begin
    RdData = '0;
    case (hilo_sel(RdHi, RdLo))
      SEL_HI:  RdData = hi_q;
      SEL_LO:  RdData = lo_q;
      default: RdData = '0;
    endcase
  end

  assign Ack               = ack_w;
  assign Busy              = busy_w;
  assign Stall             = stall_w;
  assign Mul_St            = (state_q == S_LAUNCH);
  assign Mul_Multiplicando = mag_a_q;
  assign Mul_Multiplicador = mag_b_q;

endmodule

// File: tb/tb_mul_hilo_ctrl.sv
// Bench for mul_hilo_ctrl: a behavioural unsigned multiplier (not reset by
// Rst_n) answers Mul_St; expected operand magnitudes and read data are queued
// by the stimulus and compared by a monitor when the DUT presents them.
module tb_mul_hilo_ctrl;

  logic        Clk, Rst_n, Req, Signed, RdHi, RdLo, WrHi, WrLo;
  logic [15:0] OpA, OpB, WrData, RdData, Mul_Multiplicando, Mul_Multiplicador;
  logic        Ack, Busy, Stall, Mul_St, Mul_Idle, Mul_Done;
  logic [31:0] Mul_Produto;

  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  logic [15:0] m_a = '0, m_b = '0;
  logic [31:0] m_prod = '0;
  int          m_cnt = 0;
  logic        inj_done;

  logic [31:0] mag_q[$];
  logic [15:0] rd_q[$];
  int          checks = 0;
  int          errors = 0;

  mul_hilo_ctrl #(.WIDTH(16)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Req(Req), .Signed(Signed), .OpA(OpA), .OpB(OpB),
    .Ack(Ack), .Busy(Busy), .Stall(Stall), .RdHi(RdHi), .RdLo(RdLo),
    .RdData(RdData), .WrHi(WrHi), .WrLo(WrLo), .WrData(WrData),
    .Mul_St(Mul_St), .Mul_Multiplicando(Mul_Multiplicando),
    .Mul_Multiplicador(Mul_Multiplicador), .Mul_Idle(Mul_Idle),
    .Mul_Done(Mul_Done), .Mul_Produto(Mul_Produto)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Multiplier model: fixed latency, one-cycle Done pulse, ignores Rst_n.
  always @(posedge Clk) begin
    m_done <= 1'b0;
    if (m_busy) begin
      if (m_cnt == 0) begin
        m_done <= 1'b1;
        m_prod <= {16'h0, m_a} * {16'h0, m_b};
        m_busy <= 1'b0;
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end else if (Mul_St) begin
      m_busy <= 1'b1;
      m_a    <= Mul_Multiplicando;
      m_b    <= Mul_Multiplicador;
      m_cnt  <= 5;
    end
  end

  assign Mul_Idle    = ~m_busy;
  assign Mul_Done    = m_done | inj_done;
  assign Mul_Produto = inj_done ? 32'hDEAD_BEEF : m_prod;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic monitor();
    logic [31:0] e;
    logic [15:0] r;
    forever begin
      @(negedge Clk);
      if (Mul_St) begin
        if (mag_q.size() == 0) chk("mul_st_unexpected", 32'd1, 32'd0);
        else begin
          e = mag_q.pop_front();
          chk("mul_operands", {Mul_Multiplicando, Mul_Multiplicador}, e);
        end
      end
      if ((RdHi || RdLo) && !Stall) begin
        if (rd_q.size() == 0) chk("read_unexpected", 32'd1, 32'd0);
        else begin
          r = rd_q.pop_front();
          chk("rddata", {16'h0, RdData}, {16'h0, r});
        end
      end
    end
  endtask

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  // Issue a request; returns one step after the accepting edge (state LAUNCH).
  task automatic mul(input logic s, input logic [15:0] a, input logic [15:0] b,
                     input logic [15:0] ma, input logic [15:0] mb);
    int n = 0;
    Req = 1'b1; Signed = s; OpA = a; OpB = b;
    @(negedge Clk);
    while (!Ack && n < 100) begin
      @(negedge Clk);
      n++;
    end
    chk("ack_timeout", {31'h0, Ack}, 32'd1);
    mag_q.push_back({ma, mb});
    @(posedge Clk);
    #1 Req = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge Clk);
    while (Busy && n < 100) begin
      @(negedge Clk);
      n++;
    end
    chk("idle_timeout", {31'h0, Busy}, 32'd0);
  endtask

  task automatic rd(input logic h, input logic l, input logic [15:0] exp);
    int n = 0;
    rd_q.push_back(exp);
    RdHi = h; RdLo = l;
    @(negedge Clk);
    while (Stall && n < 100) begin
      @(negedge Clk);
      n++;
    end
    chk("read_stall_timeout", {31'h0, Stall}, 32'd0);
    @(posedge Clk);
    #1 RdHi = 1'b0; RdLo = 1'b0;
  endtask

  initial begin
    int n;
    logic bad;
    Rst_n = 1'b1; Req = 0; Signed = 0; OpA = 0; OpB = 0;
    RdHi = 0; RdLo = 0; WrHi = 0; WrLo = 0; WrData = 0; inj_done = 0;
    fork monitor(); join_none
    #2 Rst_n = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_busy", {31'h0, Busy}, 32'd0);
    chk("rst_ack", {31'h0, Ack}, 32'd0);
    chk("rst_stall", {31'h0, Stall}, 32'd0);
    chk("rst_mul_st", {31'h0, Mul_St}, 32'd0);
    Rst_n = 1'b1;
    cyc();
    rd(1, 0, 16'h0000);
    rd(0, 1, 16'h0000);

    // MULTU 3 x 5 with latency checks.
    mul(0, 16'h0003, 16'h0005, 16'h0003, 16'h0005);
    @(negedge Clk);
    chk("mul_st_after_ack", {31'h0, Mul_St}, 32'd1);
    chk("busy_launch", {31'h0, Busy}, 32'd1);
    n = 0;
    while (!Mul_Done && n < 100) begin
      @(negedge Clk);
      n++;
    end
    chk("done_timeout", {31'h0, Mul_Done}, 32'd1);
    @(negedge Clk);
    chk("busy_write", {31'h0, Busy}, 32'd1);
    @(negedge Clk);
    chk("busy_after_write", {31'h0, Busy}, 32'd0);
    cyc();
    rd(1, 0, 16'h0000);
    rd(0, 1, 16'h000F);

    // Signed and boundary operands.
    mul(1, 16'hFFFF, 16'h0007, 16'h0001, 16'h0007); wait_idle(); cyc();
    rd(1, 0, 16'hFFFF); rd(0, 1, 16'hFFF9);
    mul(1, 16'h8000, 16'h8000, 16'h8000, 16'h8000); wait_idle(); cyc();
    rd(1, 0, 16'h4000); rd(0, 1, 16'h0000);
    mul(1, 16'h8000, 16'h0001, 16'h8000, 16'h0001); wait_idle(); cyc();
    rd(1, 0, 16'hFFFF); rd(0, 1, 16'h8000);
    mul(0, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF); wait_idle(); cyc();
    rd(1, 1, 16'hFFFE); rd(0, 1, 16'h0001);

    // MFHI and a second request while the first multiply is in WAIT.
    mul(0, 16'h1234, 16'h0100, 16'h1234, 16'h0100);
    cyc(); cyc();
    rd_q.push_back(16'h0012);
    RdHi = 1'b1; Req = 1'b1; Signed = 1'b0; OpA = 16'h0002; OpB = 16'h0003;
    @(negedge Clk);
    chk("stall_in_wait", {31'h0, Stall}, 32'd1);
    chk("ack_in_wait", {31'h0, Ack}, 32'd0);
    n = 0; bad = 1'b0;
    while (Busy && n < 100) begin
      @(negedge Clk);
      n++;
      if (Busy && (!Stall || Ack)) bad = 1'b1;
    end
    chk("hold_while_busy", {31'h0, bad}, 32'd0);
    chk("busy_release", {31'h0, Busy}, 32'd0);
    chk("ack_after_write", {31'h0, Ack}, 32'd1);
    mag_q.push_back({16'h0002, 16'h0003});
    @(posedge Clk);
    #1 Req = 1'b0; RdHi = 1'b0;
    wait_idle(); cyc();
    rd(1, 0, 16'h0000); rd(0, 1, 16'h0006);

    // MTLO in IDLE, then MTHI alongside an accepted request.
    WrLo = 1'b1; WrData = 16'h1234;
    cyc();
    WrLo = 1'b0;
    rd(0, 1, 16'h1234);
    WrHi = 1'b1; WrData = 16'hBEEF;
    mul(0, 16'h0002, 16'h8000, 16'h0002, 16'h8000);
    WrHi = 1'b0;
    wait_idle(); cyc();
    rd(1, 0, 16'h0001); rd(0, 1, 16'h0000);

    // Reset during WAIT, draining multiplier, stale Done.
    mul(0, 16'h00FF, 16'h00FF, 16'h00FF, 16'h00FF);
    cyc(); cyc();
    Rst_n = 1'b0;
    #1;
    chk("midrst_busy", {31'h0, Busy}, 32'd0);
    chk("midrst_mul_st", {31'h0, Mul_St}, 32'd0);
    chk("midrst_operand", {16'h0, Mul_Multiplicando}, 32'd0);
    rd(1, 0, 16'h0000);
    rd(0, 1, 16'h0000);
    Rst_n = 1'b1;
    Req = 1'b1; Signed = 1'b0; OpA = 16'h0001; OpB = 16'h0001;
    @(negedge Clk);
    chk("drain_mul_idle", {31'h0, Mul_Idle}, 32'd0);
    chk("drain_stall", {31'h0, Stall}, 32'd1);
    chk("drain_ack", {31'h0, Ack}, 32'd0);
    Req = 1'b0;
    mul(0, 16'h0001, 16'h0001, 16'h0001, 16'h0001);
    wait_idle(); cyc();
    rd(1, 0, 16'h0000); rd(0, 1, 16'h0001);
    inj_done = 1'b1;
    cyc();
    inj_done = 1'b0;
    cyc();
    chk("stale_done_busy", {31'h0, Busy}, 32'd0);
    rd(1, 0, 16'h0000); rd(0, 1, 16'h0001);

    repeat (3) cyc();
    chk("mag_q_drained", mag_q.size(), 32'd0);
    chk("rd_q_drained", rd_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
